// File: rtl/cpu_pkg.sv
// Shared types for the boot/program-loader path of the pipelined core.
package cpu_pkg;
    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_RUN} loader_state_t;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/switch_edge_sync.sv
// Synchronises a raw push-switch into CLK and emits a one-cycle pulse on its rising edge.
module switch_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic sw,
    output logic edge_pulse
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   pulse_reg;

    // Pulse is registered so the event lands SYNC_STAGES+1 cycles after the input.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], sw};
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign edge_pulse = pulse_reg;
endmodule

// File: rtl/uart_program_loader.sv
// Boot sequencer: packs UART bytes into 32-bit words, writes instruction memory,
// then releases the pipeline with a flush pulse followed by run enable.
module uart_program_loader
    import cpu_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 2,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      CLK,
    input  logic                      reset_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      sw_start,
    input  logic                      sw_end,
    output logic                      imem_we,
    output logic [INST_MEM_WIDTH-1:0] imem_addr,
    output logic [31:0]               imem_wdata,
    output logic                      cpu_flush,
    output logic                      cpu_run,
    output logic [INST_MEM_WIDTH:0]   words_loaded,
    output logic [3:0]                status
);
    localparam int CAPACITY = 1 << INST_MEM_WIDTH;
    localparam logic [INST_MEM_WIDTH:0] LAST_WORD = (INST_MEM_WIDTH+1)'(CAPACITY - 1);
    localparam logic [INST_MEM_WIDTH:0] WORD_ONE  = (INST_MEM_WIDTH+1)'(1);
    localparam logic [1:0]              LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    loader_state_t             state_reg;
    logic [1:0]                byte_cnt_reg;
    logic [INST_MEM_WIDTH:0]   word_cnt_reg;
    logic [23:0]               shift_reg;
    logic                      err_reg;
    logic                      full_reg;
    logic                      imem_we_reg;
    logic [INST_MEM_WIDTH-1:0] imem_addr_reg;
    logic [31:0]               imem_wdata_reg;
    logic                      cpu_flush_reg;
    logic                      cpu_run_reg;

    logic       start_ev;
    logic       end_ev;
    logic       word_done;
    logic       last_word;
    logic [1:0] byte_cnt_next;

    switch_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .CLK(CLK), .reset_n(reset_n), .sw(sw_start), .edge_pulse(start_ev)
    );
    switch_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_end_sync (
        .CLK(CLK), .reset_n(reset_n), .sw(sw_end), .edge_pulse(end_ev)
    );

    assign word_done     = rx_valid && (byte_cnt_reg == LAST_BYTE);
    assign last_word     = word_done && (word_cnt_reg == LAST_WORD);
    assign byte_cnt_next = rx_valid ? byte_cnt_reg + 2'd1 : byte_cnt_reg;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= LD_IDLE;
            byte_cnt_reg   <= '0;
            word_cnt_reg   <= '0;
            shift_reg      <= '0;
            err_reg        <= 1'b0;
            full_reg       <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            cpu_flush_reg  <= 1'b0;
            cpu_run_reg    <= 1'b0;
        end else begin
            imem_we_reg   <= 1'b0;
            cpu_flush_reg <= 1'b0;
            case (state_reg)
                LD_IDLE, LD_RUN: begin
                    if (state_reg == LD_RUN) cpu_run_reg <= 1'b1;
                    if (start_ev) begin
                        state_reg    <= LD_LOAD;
                        byte_cnt_reg <= '0;
                        word_cnt_reg <= '0;
                        err_reg      <= 1'b0;
                        full_reg     <= 1'b0;
                        cpu_run_reg  <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (start_ev && !end_ev) begin
                        byte_cnt_reg <= '0;
                        word_cnt_reg <= '0;
                        err_reg      <= 1'b0;
                        full_reg     <= 1'b0;
                    end else begin
                        if (rx_valid) begin
                            shift_reg    <= {shift_reg[15:0], rx_data};
                            byte_cnt_reg <= byte_cnt_next;
                        end
                        if (word_done) begin
                            imem_we_reg    <= 1'b1;
                            imem_addr_reg  <= word_cnt_reg[INST_MEM_WIDTH-1:0];
                            imem_wdata_reg <= {shift_reg, rx_data};
                            word_cnt_reg   <= word_cnt_reg + WORD_ONE;
                        end
                        // The write that fills memory and the RUN entry share one edge.
                        if (end_ev || last_word) begin
                            state_reg     <= LD_RUN;
                            full_reg      <= last_word;
                            err_reg       <= (byte_cnt_next != 2'd0);
                            cpu_flush_reg <= 1'b1;
                            cpu_run_reg   <= 1'b0;
                        end
                    end
                end
                default: state_reg <= LD_IDLE;
            endcase
        end
    end

    assign imem_we      = imem_we_reg;
    assign imem_addr    = imem_addr_reg;
    assign imem_wdata   = imem_wdata_reg;
    assign cpu_flush    = cpu_flush_reg;
    assign cpu_run      = cpu_run_reg;
    assign words_loaded = word_cnt_reg;
    assign status       = {err_reg, full_reg, state_reg == LD_LOAD, state_reg == LD_RUN};
endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: table loads, random loads, reset and glitch cases.
module tb_uart_program_loader;
    localparam int IMW = 2;
    localparam int CAP = 1 << IMW;

    logic           CLK = 1'b0;
    logic           reset_n = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic           sw_start = 1'b0;
    logic           sw_end = 1'b0;
    logic           imem_we;
    logic [IMW-1:0] imem_addr;
    logic [31:0]    imem_wdata;
    logic           cpu_flush;
    logic           cpu_run;
    logic [IMW:0]   words_loaded;
    logic [3:0]     status;

    uart_program_loader #(.INST_MEM_WIDTH(IMW), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .sw_start(sw_start), .sw_end(sw_end), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_flush(cpu_flush), .cpu_run(cpu_run),
        .words_loaded(words_loaded), .status(status)
    );

    always #5 CLK = ~CLK;

    int          cmp_cnt = 0;
    int          mis_cnt = 0;
    int          flush_cnt = 0;
    logic        prev_flush = 1'b0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    typedef struct {
        string        tag;
        int           n;
        logic [159:0] bytes;
        bit           with_end;
        int           exp_words;
        bit           exp_err;
        bit           exp_full;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observe writes and the flush/run handshake on the falling edge.
    always @(negedge CLK) begin
        if (reset_n) begin
            if (imem_we) begin
                wr_addr_q.push_back(int'(imem_addr));
                wr_data_q.push_back(imem_wdata);
                check("we_only_in_load", status[1] | cpu_flush, 1);
            end
            if (cpu_flush) begin
                flush_cnt++;
                check("run_low_in_flush", cpu_run, 0);
            end
            if (prev_flush && status[0]) check("run_after_flush", cpu_run, 1);
        end
        prev_flush = cpu_flush;
    end

    function automatic void model(input int n, output int w, output bit e, output bit f);
        f = (n >= 4 * CAP);
        w = f ? CAP : n / 4;
        e = !f && (n % 4 != 0);
    endfunction

    task automatic wait_bit(input string name, input int idx, input int limit);
        int k = 0;
        while (status[idx] !== 1'b1 && k < limit) begin
            @(negedge CLK);
            k++;
        end
        check(name, status[idx], 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic do_start();
        @(negedge CLK);
        sw_start = 1'b1;
        wait_bit("start_to_load", 1, 20);
        check("start_run_low", cpu_run, 0);
        check("start_words_clr", words_loaded, 0);
        check("start_flags_clr", status[3:2], 0);
        @(negedge CLK);
        sw_start = 1'b0;
        repeat (5) @(negedge CLK);
    endtask

    task automatic run_load(input string tag, input logic [159:0] bytes, input int n,
                            input bit with_end, input int exp_words, input bit exp_err,
                            input bit exp_full);
        do_start();
        wr_addr_q.delete();
        wr_data_q.delete();
        flush_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (with_end && i == n - 1) begin
                // End edge reaches the FSM three falling edges later, together with this byte.
                sw_end = 1'b1;
                repeat (3) @(negedge CLK);
            end
            send_byte(bytes[159 - 8 * i -: 8]);
        end
        sw_end = 1'b1;
        wait_bit("end_to_run", 0, 20);
        repeat (3) @(negedge CLK);
        sw_end = 1'b0;
        repeat (5) @(negedge CLK);
        check("words_loaded", words_loaded, exp_words);
        check("status", status, {exp_err, exp_full, 1'b0, 1'b1});
        check("flush_count", flush_cnt, 1);
        check("cpu_run", cpu_run, 1);
        check("write_count", wr_addr_q.size(), exp_words);
        for (int i = 0; i < exp_words && i < wr_addr_q.size(); i++) begin
            check("write_addr", wr_addr_q[i], i);
            check("write_data", wr_data_q[i], bytes[159 - 32 * i -: 32]);
        end
        $display("load %s: bytes=%0d end_same_cycle=%0d words=%0d status=%b",
                 tag, n, with_end, words_loaded, status);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"two_words", 8, {64'h1234_5678_9ABC_DEF0, 96'h0}, 1'b0, 2, 1'b0, 1'b0};
        vecs[1] = '{"overflow", 20, 160'h00010203_04050607_08090A0B_0C0D0E0F_10111213, 1'b0, 4, 1'b0, 1'b1};
        vecs[2] = '{"partial", 3, {24'hAABBCC, 136'h0}, 1'b0, 0, 1'b1, 1'b0};
        vecs[3] = '{"end_with_4th", 4, {32'hDEAD_BEEF, 128'h0}, 1'b1, 1, 1'b0, 1'b0};
        vecs[4] = '{"end_with_5th", 5, {40'h01_0203_0405, 120'h0}, 1'b1, 1, 1'b1, 1'b0};
        vecs[5] = '{"reload", 4, {32'hCAFE_F00D, 128'h0}, 1'b0, 1, 1'b0, 1'b0};
        vecs[6] = '{"full_with_end", 16, 160'h11223344_55667788_99AABBCC_DDEEFF00_0, 1'b1, 4, 1'b0, 1'b1};

        #1;
        check("reset_outputs", {imem_we, imem_addr, imem_wdata, cpu_flush, cpu_run, words_loaded, status}, 0);
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        repeat (2) @(negedge CLK);

        for (int v = 0; v < 7; v++)
            run_load(vecs[v].tag, vecs[v].bytes, vecs[v].n, vecs[v].with_end,
                     vecs[v].exp_words, vecs[v].exp_err, vecs[v].exp_full);

        for (int r = 0; r < 8; r++) begin
            logic [159:0] rb;
            int rn, w;
            bit e, f, we;
            rb = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rn = $urandom_range(0, 20);
            we = (rn > 0) && ($urandom_range(0, 1) == 1);
            model(rn, w, e, f);
            run_load("random", rb, rn, we, w, e, f);
        end

        // Reset in the middle of a word.
        do_start();
        send_byte(8'h55);
        send_byte(8'h66);
        wr_addr_q.delete();
        #2 reset_n = 1'b0;
        #1 check("midload_reset_outputs",
                 {imem_we, imem_addr, imem_wdata, cpu_flush, cpu_run, words_loaded, status}, 0);
        @(negedge CLK);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        check("idle_ignores_bytes", wr_addr_q.size(), 0);
        check("idle_after_reset", status, 0);
        $display("reset mid-word: status=%b writes=%0d", status, wr_addr_q.size());

        // End press in IDLE is ignored.
        sw_end = 1'b1;
        repeat (8) @(negedge CLK);
        check("idle_ignores_end", status, 0);
        sw_end = 1'b0;
        repeat (5) @(negedge CLK);

        // Sub-cycle start glitch between rising edges produces no event.
        #1 sw_start = 1'b1;
        #2 sw_start = 1'b0;
        repeat (8) @(negedge CLK);
        check("glitch_no_event", status, 0);
        $display("glitch: status=%b", status);

        run_load("after_reset", {32'h0BAD_F00D, 32'h1357_9BDF, 96'h0}, 8, 1'b0, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end
endmodule
